// File: rtl/bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// bus_arbiter_if
//   Groups the request/grant signals between the control unit's per-source
//   bus-drive requests and the round-robin bus arbiter.
//
//   Signals:
//     req         N      per-source bus request (level-sensitive)
//     lock        1      current grantee keeps the bus while its req stays high
//     grant       N      registered one-hot grant, all-zero when idle
//     sel         SEL_W  registered binary index of the grant bit, 0 when idle
//     busy        1      any grant bit set; qualifies sel
//     timeout_err 1      one-cycle pulse on forced revocation
//
//   Modports:
//     master : requester side (drives req/lock, observes grant side)
//     slave  : arbiter side (observes req/lock, drives grant side)
// ---------------------------------------------------------------------------
interface bus_arbiter_if #(
  parameter int N     = 24,
  parameter int SEL_W = 5
);
  logic [N-1:0]     req;
  logic             lock;
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic             timeout_err;

  modport master (
    output req, lock,
    input  grant, sel, busy, timeout_err
  );

  modport slave (
    input  req, lock,
    output grant, sel, busy, timeout_err
  );
endinterface

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//   Round-robin arbiter for the single internal datapath bus. Up to N sources
//   (R0-R15, HI, LO, ZHI, ZLO, PC, MDR, InPort, C -> select codes 0..23)
//   compete; the winner's one-hot grant and binary select code are registered.
//   A grantee may keep the bus across cycles with lock while its req stays
//   high. On release the pointer moves to owner+1, so the old owner becomes
//   lowest priority, and the next winner is granted on the same edge.
//
//   Ports:
//     clock  single clock, rising edge
//     clear  synchronous active-high reset
//     bus    bus_arbiter_if.slave (req, lock in; grant, sel, busy,
//            timeout_err out)
//
//   Optional feature (macro BUS_ARB_TIMEOUT_EN):
//     defined   : a hold counter limits a locked grant to MAX_HOLD cycles;
//                 the grant is then revoked, the bus rearbitrated from
//                 owner+1 and timeout_err pulses for one cycle.
//     undefined : no counter, locked grants are held indefinitely and
//                 timeout_err is tied low.
// ---------------------------------------------------------------------------
module bus_arbiter #(
  parameter int N        = 24,
  parameter int SEL_W    = 5,
  parameter int MAX_HOLD = 8
) (
  input  logic          clock,
  input  logic          clear,
  bus_arbiter_if.slave  bus
);

  // Elaboration-time parameter sanity checks.
  generate
    if ((1 << SEL_W) < N) begin : g_bad_sel_w
      $error("bus_arbiter: SEL_W too small for N");
    end
    if (MAX_HOLD < 1) begin : g_bad_max_hold
      $error("bus_arbiter: MAX_HOLD must be >= 1");
    end
  endgenerate

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // (a + b) mod N for a < N and 0 <= b < N.
  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= N) s = s - N;
    return SEL_W'(s);
  endfunction

  state_t           state_reg, state_next;
  logic [SEL_W-1:0] g_reg, g_next;
  logic [SEL_W-1:0] ptr_reg, ptr_next;
  logic [N-1:0]     grant_reg, grant_next;
  logic [SEL_W-1:0] sel_reg, sel_next;
  logic             busy_reg, busy_next;
  logic             terr_reg, terr_next;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int               CNT_W   = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HOLD);
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             expired;
`endif

  // ------------------------------------------------------------------------
  // Rotating-priority search. While a grant is active the only arbitration
  // that matters is the release one, which starts at owner+1; in IDLE it
  // starts at the stored pointer. Muxing the start point lets one search
  // serve both cases.
  // ------------------------------------------------------------------------
  logic [SEL_W-1:0] arb_ptr;
  logic [N-1:0]     rot_req;
  logic [SEL_W-1:0] win_off;
  logic [SEL_W-1:0] win_idx;
  logic             win_found;

  assign arb_ptr = (state_reg == GRANT) ? wrap_add(g_reg, 1) : ptr_reg;

  // rot_req[k] is the request of the source k places after the pointer.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rotate
      assign rot_req[gi] = bus.req[wrap_add(arb_ptr, gi)];
    end
  endgenerate

  // Lowest set offset wins; scanning downward lets the last hit win.
  always_comb begin
    win_found = 1'b0;
    win_off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        win_found = 1'b1;
        win_off   = SEL_W'(k);
      end
    end
  end

  assign win_idx = wrap_add(arb_ptr, int'(win_off));

  // ------------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (clear) begin
      state_reg <= IDLE;
      g_reg     <= '0;
      ptr_reg   <= '0;
      grant_reg <= '0;
      sel_reg   <= '0;
      busy_reg  <= 1'b0;
      terr_reg  <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      g_reg     <= g_next;
      ptr_reg   <= ptr_next;
      grant_reg <= grant_next;
      sel_reg   <= sel_next;
      busy_reg  <= busy_next;
      terr_reg  <= terr_next;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_reg   <= cnt_next;
`endif
    end
  end

  // ------------------------------------------------------------------------
  // Next-state / output logic
  // ------------------------------------------------------------------------
  logic hold;

  always_comb begin
    state_next = state_reg;
    g_next     = g_reg;
    ptr_next   = ptr_reg;
    grant_next = grant_reg;
    sel_next   = sel_reg;
    busy_next  = busy_reg;
    terr_next  = 1'b0;
    hold       = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
    cnt_next   = cnt_reg;
    // A locked owner that has used up its budget is forcibly revoked; if its
    // req drops on the same edge the revocation is still reported.
    expired    = bus.lock && (cnt_reg >= MAX_CNT);
`endif

    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next = GRANT;
          g_next     = win_idx;
          grant_next = {{(N-1){1'b0}}, 1'b1} << win_idx;
          sel_next   = win_idx;
          busy_next  = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
          cnt_next   = CNT_W'(1);
`endif
        end
      end

      GRANT: begin
`ifdef BUS_ARB_TIMEOUT_EN
        hold = bus.req[g_reg] && bus.lock && !expired;
`else
        hold = bus.req[g_reg] && bus.lock;
`endif
        if (hold) begin
`ifdef BUS_ARB_TIMEOUT_EN
          if (cnt_reg < MAX_CNT) cnt_next = cnt_reg + CNT_W'(1);
`endif
        end else begin
          // Release: old owner drops to lowest priority, regrant without a
          // bubble if anyone (including the old owner) is still asking.
          ptr_next = wrap_add(g_reg, 1);
`ifdef BUS_ARB_TIMEOUT_EN
          terr_next = expired;
`endif
          if (win_found) begin
            g_next     = win_idx;
            grant_next = {{(N-1){1'b0}}, 1'b1} << win_idx;
            sel_next   = win_idx;
            busy_next  = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt_next   = CNT_W'(1);
`endif
          end else begin
            state_next = IDLE;
            grant_next = '0;
            sel_next   = '0;
            busy_next  = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt_next   = '0;
`endif
          end
        end
      end

      default: begin
        state_next = IDLE;
        grant_next = '0;
        sel_next   = '0;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign bus.grant       = grant_reg;
  assign bus.sel         = sel_reg;
  assign bus.busy        = busy_reg;
  assign bus.timeout_err = terr_reg;

endmodule
